mem_access_unit: RTL and testbench

MEM-stage load/store front end that sits directly upstream of the byte-select data RAM. It takes a byte-addressed load/store request from the pipeline and checks alignment. It converts the request into the RAM word address, byte-select and lane-aligned write data, and drives the RAM for exactly one access cycle. It then captures the RAM's right-justified, zero-extended read data, applies sign/zero extension, and returns a one-cycle response with an error flag for misaligned accesses.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_lane_ctrl.sv | 48 ++++
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store front end.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    function automatic logic is_store(mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(mem_op_t op, logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = a[0];
            OP_LW, OP_SW:         mis = (a != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_ctrl.sv
// Combinational lane steering: byte enables and write-lane replication on the way out,
// sign/zero extension of the right-justified RAM read data on the way back.
module mem_lane_ctrl
    import mem_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] lane_wdata_o,
    input  mem_op_t     rd_op_i,
    input  logic [31:0] rdata_raw_i,
    output logic [31:0] rdata_ext_o
);

    always_comb begin
        sel_o        = 4'b1111;
        lane_wdata_o = wdata_i;
        case (op_i)
            OP_LB, OP_LBU, OP_SB: begin
                sel_o        = 4'b0001 << addr_lo_i;
                lane_wdata_o = {4{wdata_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                sel_o        = 4'b1111;
                lane_wdata_o = wdata_i;
            end
        endcase
    end

    // RAM already right-justifies the selected lanes, so only extension is needed here.
    always_comb begin
        rdata_ext_o = 32'h0;
        case (rd_op_i)
            OP_LB:   rdata_ext_o = {{24{rdata_raw_i[7]}}, rdata_raw_i[7:0]};
            OP_LH:   rdata_ext_o = {{16{rdata_raw_i[15]}}, rdata_raw_i[15:0]};
            OP_LBU:  rdata_ext_o = {24'h0, rdata_raw_i[7:0]};
            OP_LHU:  rdata_ext_o = {16'h0, rdata_raw_i[15:0]};
            OP_LW:   rdata_ext_o = rdata_raw_i;
            default: rdata_ext_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: one registered RAM access per request, then a
// one-cycle response; misaligned requests bypass the RAM and return an error.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              ram_rw_o,
    output logic [3:0]        ram_sel_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_data_in_o,
    input  logic [31:0]       ram_data_out_i
);

    state_e              state_q;
    mem_op_t             op_q;
    logic                ram_rw_q;
    logic [3:0]          ram_sel_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic [31:0]         ram_data_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [31:0]         resp_rdata_q;

    mem_op_t             req_op;
    logic [3:0]          lane_sel;
    logic [31:0]         lane_wdata;
    logic [31:0]         rdata_ext;
    logic                unused_addr_hi;

    assign req_op         = mem_op_t'(req_op_i);
    assign unused_addr_hi = ^req_addr_i[31:RAM_AW+2];

    mem_lane_ctrl u_lane_ctrl (
        .op_i         (req_op),
        .addr_lo_i    (req_addr_i[1:0]),
        .wdata_i      (req_wdata_i),
        .sel_o        (lane_sel),
        .lane_wdata_o (lane_wdata),
        .rd_op_i      (op_q),
        .rdata_raw_i  (ram_data_out_i),
        .rdata_ext_o  (rdata_ext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            op_q         <= OP_LB;
            ram_rw_q     <= 1'b0;
            ram_sel_q    <= 4'b0000;
            ram_addr_q   <= '0;
            ram_data_q   <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle, StResp: begin
                    state_q      <= StIdle;
                    ram_rw_q     <= 1'b0;
                    ram_sel_q    <= 4'b0000;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    if (req_valid_i) begin
                        op_q <= req_op;
                        if (is_misaligned(req_op, req_addr_i[1:0])) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q    <= StAccess;
                            ram_rw_q   <= is_store(req_op);
                            ram_sel_q  <= lane_sel;
                            ram_addr_q <= req_addr_i[RAM_AW+1:2];
                            ram_data_q <= lane_wdata;
                        end
                    end
                end
                StAccess: begin
                    // RAM completed the access on the intervening negedge.
                    state_q      <= StResp;
                    ram_rw_q     <= 1'b0;
                    ram_sel_q    <= 4'b0000;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= rdata_ext;
                end
                default: begin
                    state_q   <= StIdle;
                    ram_rw_q  <= 1'b0;
                    ram_sel_q <= 4'b0000;
                end
            endcase
        end
    end

    assign req_ready_o   = (state_q != StAccess);
    assign resp_valid_o  = resp_valid_q;
    assign resp_rdata_o  = resp_rdata_q;
    assign resp_err_o    = resp_err_q;
    assign ram_rw_o      = ram_rw_q;
    assign ram_sel_o     = ram_sel_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_data_in_o = ram_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: negedge byte-select RAM model, byte-level reference memory,
// directed vector table, hand-written multi-cycle sequences and randomized requests.
module tb_mem_access_unit;

    localparam int unsigned AW = 10;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4,
                           SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          ram_rw;
    logic [3:0]    ram_sel;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram_mem [1 << AW];
    logic [7:0]  ref_mem [4 << AW];

    mem_access_unit #(.RAM_AW(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .ram_rw_o       (ram_rw),
        .ram_sel_o      (ram_sel),
        .ram_addr_o     (ram_addr),
        .ram_data_in_o  (ram_din),
        .ram_data_out_i (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect the selected bytes, lowest lane first, into the low end of the result.
    function automatic logic [31:0] right_justify(input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        int k;
        r = 32'h0;
        k = 0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                r[8*k +: 8] = w[8*b +: 8];
                k++;
            end
        end
        return r;
    endfunction

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= 32'h0;
            ram_dout <= 32'h0;
        end else if (ram_sel != 4'b0000) begin
            if (ram_rw) begin
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= right_justify(ram_mem[ram_addr], ram_sel);
            end
        end
    end

    function automatic int size_of(input logic [2:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic is_st(input logic [2:0] op);
        return op >= SB;
    endfunction

    function automatic logic model_mis(input logic [2:0] op, input logic [31:0] a);
        return (a % size_of(op)) != 0;
    endfunction

    function automatic logic [3:0] model_sel(input logic [2:0] op, input logic [31:0] a);
        int n;
        n = size_of(op);
        return 4'((((1 << n) - 1) << a[1:0]) & 15);
    endfunction

    function automatic logic [31:0] model_din(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = size_of(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = size_of(op);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[11:0]) + i];
        if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
        if (op == LH && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle or responding.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] e_sel, input logic [31:0] e_din,
                          input logic [31:0] e_rd, input logic e_err, input string tag);
        int n;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (e_err) begin
            chk({tag, ".vld"}, 32'(resp_valid), 32'd1);
            chk({tag, ".err"}, 32'(resp_err), 32'd1);
            chk({tag, ".rd"}, resp_rdata, 32'h0);
            chk({tag, ".idle"}, {27'h0, ram_rw, ram_sel}, 32'h0);
        end else begin
            chk({tag, ".busy"}, {30'h0, req_ready, resp_valid}, 32'h0);
            chk({tag, ".sel"}, 32'(ram_sel), 32'(e_sel));
            chk({tag, ".rw"}, 32'(ram_rw), 32'(is_st(op)));
            chk({tag, ".addr"}, 32'(ram_addr), 32'(addr[AW+1:2]));
            if (is_st(op)) begin
                chk({tag, ".din"}, ram_din, e_din);
                for (int i = 0; i < size_of(op); i++)
                    ref_mem[int'(addr[11:0]) + i] = wd[8*i +: 8];
            end
            @(posedge clk); #1;
            chk({tag, ".vld"}, 32'(resp_valid), 32'd1);
            chk({tag, ".err"}, 32'(resp_err), 32'd0);
            chk({tag, ".rd"}, resp_rdata, e_rd);
            chk({tag, ".idle"}, {27'h0, ram_rw, ram_sel}, 32'h0);
        end
        @(posedge clk); #1;
        chk({tag, ".end"}, 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic [31:0] din;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, wd, e_rd;
        logic        mis;
        int          seen;

        for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rst       = 1'b1;
        #3;
        chk("rst.out", {ram_rw, ram_sel, resp_valid, resp_err, req_ready}, 32'h1);
        chk("rst.addr", 32'(ram_addr), 32'h0);
        chk("rst.din", ram_din, 32'h0);
        chk("rst.rd", resp_rdata, 32'h0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        vecs[0]  = '{SW,  32'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{LB,  32'h013, 32'h0, 4'h8, 32'h0, 32'hFFFFFFDE, 1'b0};
        vecs[2]  = '{LBU, 32'h013, 32'h0, 4'h8, 32'h0, 32'h000000DE, 1'b0};
        vecs[3]  = '{LW,  32'h010, 32'h0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{SH,  32'h012, 32'h00001234, 4'hC, 32'h12341234, 32'h0, 1'b0};
        vecs[5]  = '{LHU, 32'h012, 32'h0, 4'hC, 32'h0, 32'h00001234, 1'b0};
        vecs[6]  = '{LW,  32'h010, 32'h0, 4'hF, 32'h0, 32'h1234BEEF, 1'b0};
        vecs[7]  = '{LH,  32'h011, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[8]  = '{SW,  32'h016, 32'h55555555, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{LH,  32'h010, 32'h0, 4'h3, 32'h0, 32'hFFFFBEEF, 1'b0};
        vecs[10] = '{SB,  32'h011, 32'hFFFFFF7F, 4'h2, 32'h7F7F7F7F, 32'h0, 1'b0};
        vecs[11] = '{LB,  32'h011, 32'h0, 4'h2, 32'h0, 32'h0000007F, 1'b0};
        vecs[12] = '{LBU, 32'h012, 32'h0, 4'h4, 32'h0, 32'h00000034, 1'b0};
        vecs[13] = '{LW,  32'h10000010, 32'h0, 4'hF, 32'h0, 32'h12347FEF, 1'b0};
        vecs[14] = '{LHU, 32'h013, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[15] = '{LW,  32'h012, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};

        for (int i = 0; i < 16; i++)
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].sel, vecs[i].din,
                   vecs[i].rd, vecs[i].err, $sformatf("vec%0d", i));

        // Back-to-back: the load is presented while the store is still in its access cycle.
        req_valid = 1'b1; req_op = SB; req_addr = 32'h020; req_wdata = 32'h000000A5;
        @(posedge clk); #1;
        chk("b2b.acc0", {req_ready, ram_rw, ram_sel}, {1'b0, 1'b1, 4'b0001});
        chk("b2b.din", ram_din, 32'hA5A5A5A5);
        ref_mem[32] = 8'hA5;
        req_op = LB;
        @(posedge clk); #1;
        chk("b2b.resp0", {resp_valid, req_ready, resp_err}, {1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b.acc1", {resp_valid, req_ready, ram_rw, ram_sel}, {1'b0, 1'b0, 1'b0, 4'b0001});
        @(posedge clk); #1;
        chk("b2b.vld1", 32'(resp_valid), 32'd1);
        chk("b2b.rd1", resp_rdata, 32'hFFFFFFA5);
        @(posedge clk); #1;
        chk("b2b.end", 32'(resp_valid), 32'd0);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
            wd   = $urandom;
            mis  = model_mis(op, a);
            e_rd = (mis || is_st(op)) ? 32'h0 : model_load(op, a);
            do_req(op, a, wd, model_sel(op, a), model_din(op, wd), e_rd, mis,
                   $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a store's access cycle.
        req_valid = 1'b1; req_op = SW; req_addr = 32'h030; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstacc.rw", 32'(ram_rw), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstacc.drop", {ram_rw, ram_sel, resp_valid, req_ready}, 32'h1);
        for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h0;
        @(posedge clk); #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("rstacc.noresp", 32'(seen), 32'd0);
        do_req(LW, 32'h030, 32'h0, 4'hF, 32'h0, model_load(LW, 32'h030), 1'b0, "rstacc.lw");
        do_req(LW, 32'h010, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, "rstacc.lw2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
